// File: rtl/exu_alu_mc.sv
// Integer ALU with single-cycle logic/arith ops and iterative multiply/divide.
// Multi-cycle ops run one bit per cycle for XLEN cycles on a shared hi/lo register pair.
module exu_alu_mc #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned FUNCT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FUNCT_WIDTH-1:0] funct,
    input  logic [XLEN-1:0]        alu_a,
    input  logic [XLEN-1:0]        alu_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        alu_result,
    output logic                   busy
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned CW  = SHW + 1;

    localparam logic [FUNCT_WIDTH-1:0] FN_ADD    = FUNCT_WIDTH'(1);
    localparam logic [FUNCT_WIDTH-1:0] FN_SUB    = FUNCT_WIDTH'(2);
    localparam logic [FUNCT_WIDTH-1:0] FN_AND    = FUNCT_WIDTH'(3);
    localparam logic [FUNCT_WIDTH-1:0] FN_OR     = FUNCT_WIDTH'(4);
    localparam logic [FUNCT_WIDTH-1:0] FN_XOR    = FUNCT_WIDTH'(5);
    localparam logic [FUNCT_WIDTH-1:0] FN_SLL    = FUNCT_WIDTH'(6);
    localparam logic [FUNCT_WIDTH-1:0] FN_SRL    = FUNCT_WIDTH'(7);
    localparam logic [FUNCT_WIDTH-1:0] FN_SRA    = FUNCT_WIDTH'(8);
    localparam logic [FUNCT_WIDTH-1:0] FN_LTU    = FUNCT_WIDTH'(9);
    localparam logic [FUNCT_WIDTH-1:0] FN_LTS    = FUNCT_WIDTH'(10);
    localparam logic [FUNCT_WIDTH-1:0] FN_EQ     = FUNCT_WIDTH'(11);
    localparam logic [FUNCT_WIDTH-1:0] FN_NEQ    = FUNCT_WIDTH'(12);
    localparam logic [FUNCT_WIDTH-1:0] FN_MUL    = FUNCT_WIDTH'(13);
    localparam logic [FUNCT_WIDTH-1:0] FN_MULHU  = FUNCT_WIDTH'(14);
    localparam logic [FUNCT_WIDTH-1:0] FN_DIVU   = FUNCT_WIDTH'(15);
    localparam logic [FUNCT_WIDTH-1:0] FN_REMU   = FUNCT_WIDTH'(16);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [FUNCT_WIDTH-1:0] funct_q, funct_d;
    logic [XLEN-1:0]        a_q, a_d;
    logic [XLEN-1:0]        b_q, b_d;
    logic [XLEN-1:0]        hi_q, hi_d;
    logic [XLEN-1:0]        lo_q, lo_d;
    logic [XLEN-1:0]        result_d;

    logic [XLEN:0]          mul_sum;
    logic [XLEN-1:0]        mul_hi, mul_lo;
    logic [XLEN:0]          div_sh;
    logic                   div_ge;
    logic [XLEN-1:0]        div_diff;
    logic [XLEN-1:0]        div_hi, div_lo;
    logic                   is_div;

    // Result of any single-cycle function code; unknown codes give 0.
    function automatic logic [XLEN-1:0] single_op(input logic [FUNCT_WIDTH-1:0] f,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
        logic [SHW-1:0] sa;
        sa = b[SHW-1:0];
        case (f)
            FN_ADD:  single_op = a + b;
            FN_SUB:  single_op = a - b;
            FN_AND:  single_op = a & b;
            FN_OR:   single_op = a | b;
            FN_XOR:  single_op = a ^ b;
            FN_SLL:  single_op = a << sa;
            FN_SRL:  single_op = a >> sa;
            FN_SRA:  single_op = $unsigned($signed(a) >>> sa);
            FN_LTU:  single_op = XLEN'(a < b);
            FN_LTS:  single_op = XLEN'($signed(a) < $signed(b));
            FN_EQ:   single_op = XLEN'(a == b);
            FN_NEQ:  single_op = XLEN'(a != b);
            default: single_op = '0;
        endcase
    endfunction

    function automatic logic is_multi(input logic [FUNCT_WIDTH-1:0] f);
        is_multi = (f == FN_MUL) || (f == FN_MULHU) || (f == FN_DIVU) || (f == FN_REMU);
    endfunction

    // Next state, iteration step and result selection.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        funct_d  = funct_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = alu_result;

        // shift-add step: add multiplicand into the upper half, shift product right
        mul_sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? a_q : '0)};
        mul_hi   = mul_sum[XLEN:1];
        mul_lo   = {mul_sum[0], lo_q[XLEN-1:1]};
        // restoring step: bring in next dividend bit, subtract when it fits
        div_sh   = {hi_q, lo_q[XLEN-1]};
        div_ge   = (div_sh >= {1'b0, b_q});
        div_diff = div_sh[XLEN-1:0] - b_q;
        div_hi   = div_ge ? div_diff : div_sh[XLEN-1:0];
        div_lo   = {lo_q[XLEN-2:0], div_ge};
        is_div   = (funct_q == FN_DIVU) || (funct_q == FN_REMU);

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    funct_d = funct;
                    a_d     = alu_a;
                    b_d     = alu_b;
                    cnt_d   = '0;
                    if (is_multi(funct)) begin
                        state_d = S_CALC;
                        hi_d    = '0;
                        lo_d    = ((funct == FN_DIVU) || (funct == FN_REMU)) ? alu_a : alu_b;
                    end else begin
                        state_d  = S_DONE;
                        result_d = single_op(funct, alu_a, alu_b);
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + CW'(1);
                hi_d  = is_div ? div_hi : mul_hi;
                lo_d  = is_div ? div_lo : mul_lo;
                if (cnt_q == CW'(XLEN - 1)) begin
                    state_d = S_DONE;
                    case (funct_q)
                        FN_MUL:   result_d = mul_lo;
                        FN_MULHU: result_d = mul_hi;
                        FN_DIVU:  result_d = div_lo;
                        FN_REMU:  result_d = div_hi;
                        default:  result_d = '0;
                    endcase
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d  = S_IDLE;
                    result_d = '0;
                end
            end
            default: begin
                state_d  = S_IDLE;
                result_d = '0;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            funct_q    <= '0;
            a_q        <= '0;
            b_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            alu_result <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            funct_q    <= funct_d;
            a_q        <= a_d;
            b_q        <= b_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            alu_result <= result_d;
            out_valid  <= (state_d == S_DONE);
            busy       <= (state_d != S_IDLE);
            in_ready   <= (state_d == S_IDLE);
        end
    end

endmodule
